// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, shifts out data/parity/stop
// on device clock falls, checks the device acknowledge bit, and guards the frame with a watchdog.
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);
    localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, ACK, WAIT_REL} state_t;

    state_t                state, state_next;
    logic [FILTER_LEN-1:0] filt;
    logic                  f_clk, d_sync, fall;
    logic [8:0]            frame, frame_next;
    logic [3:0]            bit_cnt, bit_cnt_next;
    logic [CW-1:0]         cnt, cnt_next, cnt_inc;
    logic                  c_oe, c_oe_next, d_oe, d_oe_next;
    logic                  done_next, err_next;

    // Open-collector drive: only ever pull low or release.
    assign ps2c = c_oe ? 1'b0 : 1'bz;
    assign ps2d = d_oe ? 1'b0 : 1'bz;

    // The idle flag is masked during a done/err pulse so a strobe in that cycle is dropped.
    assign tx_idle = (state == IDLE) && !tx_done_tick && !tx_err;
    assign fall    = f_clk && (filt == '0);
    assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt   <= '1;
            f_clk  <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            filt   <= {filt[FILTER_LEN-2:0], ps2c};
            d_sync <= ps2d;
            if (filt == '0)
                f_clk <= 1'b0;
            else if (&filt)
                f_clk <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        state_next   = state;
        frame_next   = frame;
        bit_cnt_next = bit_cnt;
        cnt_next     = cnt;
        d_oe_next    = d_oe;
        done_next    = 1'b0;
        err_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_ps2 && tx_idle) begin
                    frame_next   = {~^din, din};
                    bit_cnt_next = '0;
                    cnt_next     = '0;
                    state_next   = RTS;
                end
            end
            RTS: begin
                if (cnt == RTS_LAST) begin
                    state_next = START;
                    d_oe_next  = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            START: begin
                cnt_next   = '0;
                state_next = DATA;
            end
            DATA, ACK: begin
                if (fall) begin
                    cnt_next     = '0;
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (state == ACK) begin
                        if (d_sync) begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = WAIT_REL;
                        end
                    end else if (bit_cnt == 4'd9) begin
                        d_oe_next  = 1'b0;
                        state_next = ACK;
                    end else begin
                        d_oe_next = ~frame[bit_cnt];
                    end
                end else if (cnt == TO_LAST) begin
                    d_oe_next  = 1'b0;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            WAIT_REL: begin
                if (f_clk && d_sync) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (fall) begin
                    cnt_next = '0;
                end else if (cnt == TO_LAST) begin
                    d_oe_next  = 1'b0;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
        c_oe_next = (state_next == RTS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            frame        <= '0;
            bit_cnt      <= '0;
            cnt          <= '0;
            c_oe         <= 1'b0;
            d_oe         <= 1'b0;
            tx_done_tick <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            state        <= state_next;
            frame        <= frame_next;
            bit_cnt      <= bit_cnt_next;
            cnt          <= cnt_next;
            c_oe         <= c_oe_next;
            d_oe         <= d_oe_next;
            tx_done_tick <= done_next;
            tx_err       <= err_next;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames, captures the wire bits and
// compares them with the frame the byte must produce; a monitor checks pulses and idle lines.
module tb_ps2_host_tx;
    localparam int RTS  = 20;
    localparam int TO   = 500;
    localparam int FL   = 4;
    localparam int HALF = 20;

    logic       clk = 1'b0, rst = 1'b0, wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c = 1'b0, dev_d = 1'b0;
    logic       tx_idle, tx_done_tick, tx_err;
    wire        ps2c, ps2d;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    int checks = 0, failures = 0;
    int done_cnt = 0, err_cnt = 0;
    int cyc = 0, last_fall_cyc = 0, err_cyc = 0;
    logic prev_done = 1'b0, prev_err = 1'b0;

    ps2_host_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk(clk), .rst(rst), .wr_ps2(wr_ps2), .din(din), .ps2c(ps2c), .ps2d(ps2d),
        .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_err(tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle rules: pulses one cycle wide and exclusive, not idle during a pulse,
    // idle right after one, and an idle host never pulls a line low.
    always @(negedge clk) begin
        if (rst) begin
            check("pulse_excl", 32'(tx_done_tick & tx_err), 0);
            check("pulse_width", 32'((tx_done_tick & prev_done) | (tx_err & prev_err)), 0);
            if (tx_done_tick || tx_err) check("idle_in_pulse", 32'(tx_idle), 0);
            if (prev_done || prev_err) check("idle_after_pulse", 32'(tx_idle), 1);
            if (tx_idle) check("idle_lines", 32'({ps2c | dev_c, ps2d | dev_d}), 32'b11);
            if (tx_done_tick) done_cnt++;
            if (tx_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            prev_done = tx_done_tick;
            prev_err  = tx_err;
        end
    end

    function automatic logic [10:0] wire_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic dev_fall(output logic s);
        s     = ps2d;
        dev_c = 1'b1;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        dev_c = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic device_frame(input logic ack, input int nfall, input logic glitch,
                                output logic [10:0] bits);
        bits = '1;
        repeat (30) @(negedge clk);
        for (int i = 0; i < nfall; i++) begin
            if (i == 10) begin
                bits[i] = ps2d;
                dev_c = 1'b1;
                dev_d = ack;
                repeat (HALF) @(negedge clk);
                dev_c = 1'b0;
                repeat (HALF) @(negedge clk);
                dev_d = 1'b0;
                repeat (HALF) @(negedge clk);
            end else if (glitch && i == 3) begin
                bits[i] = ps2d;
                dev_c = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_c = 1'b0;
                repeat (8) @(negedge clk);
                dev_c = 1'b1;
                repeat (2) @(negedge clk);
                dev_c = 1'b0;
                repeat (HALF - 10) @(negedge clk);
            end else begin
                dev_fall(bits[i]);
            end
        end
    endtask

    task automatic start_frame(input logic [7:0] b);
        int len = 0;
        check("idle_before", 32'(tx_idle), 1);
        strobe(b);
        check("accept_idle_low", 32'(tx_idle), 0);
        check("accept_clk_low", 32'(ps2c), 0);
        while (ps2c === 1'b0 && len < 1000) begin
            len++;
            @(negedge clk);
        end
        check("rts_len", len, RTS);
        check("start_bit_drive", 32'(ps2d), 0);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic ack, input int nfall,
                             input logic glitch, input logic busy, output logic [10:0] bits);
        int d0 = done_cnt, e0 = err_cnt, n = 0;
        logic [10:0] exp = wire_frame(b);
        start_frame(b);
        fork
            device_frame(ack, nfall, glitch, bits);
            if (busy) begin
                repeat (200) @(negedge clk);
                strobe(8'h00);
            end
        join
        while (done_cnt == d0 && err_cnt == e0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (nfall == 11) begin
            check("wire_bits", 32'(bits), 32'(exp));
            check("done_count", done_cnt - d0, ack ? 1 : 0);
            check("err_count", err_cnt - e0, ack ? 0 : 1);
        end else begin
            check("partial_bits", 32'(bits[4:0]), 32'(exp[4:0]));
            check("timeout_err", err_cnt - e0, 1);
            check("timeout_no_done", done_cnt - d0, 0);
            check("timeout_delay", err_cyc - last_fall_cyc, 1 + FL + TO);
        end
        @(negedge clk);
        check("idle_after", 32'(tx_idle), 1);
        check("lines_released", 32'({ps2c, ps2d}), 32'b11);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [10:0] bits;
        logic        s;
        int          d0, e0;

        repeat (3) @(negedge clk);
        check("rst_idle", 32'(tx_idle), 1);
        check("rst_pulses", 32'({tx_done_tick, tx_err}), 0);
        check("rst_lines", 32'({ps2c, ps2d}), 32'b11);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(8'hF4, 1'b1, 11, 1'b0, 1'b0, bits);
        check("f4_literal", 32'(bits), 32'h5E8);
        run_frame(8'hFF, 1'b1, 11, 1'b0, 1'b0, bits);
        check("ff_literal", 32'(bits), 32'h7FE);
        run_frame(8'hF4, 1'b0, 11, 1'b0, 1'b0, bits);
        run_frame(8'hF4, 1'b1, 5, 1'b0, 1'b0, bits);
        run_frame(8'hF4, 1'b1, 11, 1'b0, 1'b1, bits);
        check("busy_literal", 32'(bits), 32'h5E8);
        run_frame(8'hF4, 1'b1, 11, 1'b1, 1'b0, bits);
        check("glitch_literal", 32'(bits), 32'h5E8);

        for (int k = 0; k < 6; k++)
            run_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, 11, 1'b0, 1'b0, bits);

        // Mid-frame reset at fall 6 while the host drives d5 = 0 (0x5A).
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(8'h5A);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 5; i++) dev_fall(s);
        dev_c = 1'b1;
        repeat (FL + 4) @(negedge clk);
        check("d5_driven", 32'(ps2d), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data_released", 32'(ps2d), 1);
        check("reset_idle", 32'(tx_idle), 1);
        check("reset_pulses", 32'({tx_done_tick, tx_err}), 0);
        @(negedge clk);
        rst = 1'b1;
        dev_c = 1'b0;
        repeat (HALF) @(negedge clk);
        check("reset_clk_released", 32'(ps2c), 1);
        repeat (100) @(negedge clk);
        check("reset_no_done", done_cnt - d0, 0);
        check("reset_no_err", err_cnt - e0, 0);

        run_frame(8'h3C, 1'b1, 11, 1'b0, 1'b0, bits);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
